mem_arb: RTL and testbench

- Two-requester arbiter that shares the single four-banked main memory between the instruction-cache controller (I side) and the data-cache controller (D side).
- Ownership is granted per burst. A burst is a 4-word line fill, or a 4-word writeback followed by a fill.
- The arbiter holds the grant until the owner releases it, and steers the owner's memory interface onto the shared memory port.
- Sits between the two cache controllers and the memory module inside the memory system.

---
 rtl/mem_arb.sv | 119 +++++++++++
 tb/tb_mem_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Burst-granular arbiter sharing one memory port between the I-cache and D-cache controllers.
// Grant is held for the whole burst; a hold watchdog flags overly long ownership.
module mem_arb #(
    parameter int unsigned MAX_HOLD = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data_in,
    input  logic        i_wr,
    input  logic        i_rd,
    output logic        i_gnt,
    output logic        i_stall,
    output logic [15:0] i_data_out,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    input  logic        d_wr,
    input  logic        d_rd,
    output logic        d_gnt,
    output logic        d_stall,
    output logic [15:0] d_data_out,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_wr,
    output logic        mem_rd,
    input  logic [15:0] mem_data_out,
    input  logic        mem_stall,
    output logic        err
);

    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t          state;
    logic            last_d;     // 1 when D was the most recent side to release
    logic [CW-1:0]   hold_cnt;

    // Ownership FSM with watchdog counter; hold_cnt clears on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (i_req && d_req) begin
                        state <= last_d ? OWN_I : OWN_D;
                    end else if (i_req) begin
                        state <= OWN_I;
                    end else if (d_req) begin
                        state <= OWN_D;
                    end
                end
                OWN_I: begin
                    if (i_req) begin
                        if (hold_cnt != CW'(MAX_HOLD)) hold_cnt <= hold_cnt + CW'(1);
                    end else begin
                        last_d   <= 1'b0;
                        hold_cnt <= '0;
                        state    <= d_req ? OWN_D : IDLE;
                    end
                end
                OWN_D: begin
                    if (d_req) begin
                        if (hold_cnt != CW'(MAX_HOLD)) hold_cnt <= hold_cnt + CW'(1);
                    end else begin
                        last_d   <= 1'b1;
                        hold_cnt <= '0;
                        state    <= i_req ? OWN_I : IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign i_gnt = (state == OWN_I);
    assign d_gnt = (state == OWN_D);

    // Counter reaches MAX_HOLD at the end of this cycle; saturation keeps it a single pulse.
    assign err = (i_gnt || d_gnt) && (hold_cnt == CW'(MAX_HOLD - 1));

    // Steer the owner onto the shared port; the non-owner never reaches memory.
    always_comb begin
        mem_addr    = '0;
        mem_data_in = '0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        if (i_gnt) begin
            mem_addr    = i_addr;
            mem_data_in = i_data_in;
            mem_wr      = i_wr & i_req;
            mem_rd      = i_rd & i_req;
        end else if (d_gnt) begin
            mem_addr    = d_addr;
            mem_data_in = d_data_in;
            mem_wr      = d_wr & d_req;
            mem_rd      = d_rd & d_req;
        end
    end

    assign i_data_out = i_gnt ? mem_data_out : 16'h0000;
    assign d_data_out = d_gnt ? mem_data_out : 16'h0000;
    assign i_stall    = i_gnt ? mem_stall : i_req;
    assign d_stall    = d_gnt ? mem_stall : d_req;

endmodule

// File: tb/tb_mem_arb.sv
// Directed plus randomized bench for mem_arb against an owner/last-served/hold-length model.
module tb_mem_arb;

    localparam int unsigned MAX_HOLD = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, i_rd, d_req, d_wr, d_rd, mem_stall;
    logic [15:0] i_addr, i_data_in, d_addr, d_data_in, mem_data_out;
    logic        i_gnt, i_stall, d_gnt, d_stall, mem_wr, mem_rd, err;
    logic [15:0] i_data_out, d_data_out, mem_addr, mem_data_in;

    int checks = 0;
    int errors = 0;

    // Model: owner 0=none 1=I 2=D, last side to release, length of current ownership in cycles.
    int m_owner = 0;
    int m_last  = 1;
    int m_held  = 0;

    always #5 clk = ~clk;

    mem_arb #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data_in(i_data_in), .i_wr(i_wr), .i_rd(i_rd),
        .i_gnt(i_gnt), .i_stall(i_stall), .i_data_out(i_data_out),
        .d_req(d_req), .d_addr(d_addr), .d_data_in(d_data_in), .d_wr(d_wr), .d_rd(d_rd),
        .d_gnt(d_gnt), .d_stall(d_stall), .d_data_out(d_data_out),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_data_out(mem_data_out), .mem_stall(mem_stall), .err(err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int prev;
        prev = m_owner;
        if (rst) begin
            m_owner = 0;
            m_last  = 1;
        end else if (m_owner == 0) begin
            if (i_req && d_req) m_owner = (m_last == 1) ? 2 : 1;
            else if (i_req)     m_owner = 1;
            else if (d_req)     m_owner = 2;
        end else if (m_owner == 1 && !i_req) begin
            m_last  = 1;
            m_owner = d_req ? 2 : 0;
        end else if (m_owner == 2 && !d_req) begin
            m_last  = 2;
            m_owner = i_req ? 1 : 0;
        end
        if (m_owner == 0)          m_held = 0;
        else if (m_owner == prev)  m_held = m_held + 1;
        else                       m_held = 1;
    endtask

    task automatic check_outputs();
        logic [15:0] e_addr, e_wdata;
        logic        e_wr, e_rd;
        e_addr = 16'h0; e_wdata = 16'h0; e_wr = 1'b0; e_rd = 1'b0;
        if (m_owner == 1) begin
            e_addr = i_addr; e_wdata = i_data_in; e_wr = i_wr & i_req; e_rd = i_rd & i_req;
        end else if (m_owner == 2) begin
            e_addr = d_addr; e_wdata = d_data_in; e_wr = d_wr & d_req; e_rd = d_rd & d_req;
        end
        chk("i_gnt", 16'(i_gnt), 16'(m_owner == 1));
        chk("d_gnt", 16'(d_gnt), 16'(m_owner == 2));
        chk("i_stall", 16'(i_stall), 16'((m_owner == 1) ? mem_stall : i_req));
        chk("d_stall", 16'(d_stall), 16'((m_owner == 2) ? mem_stall : d_req));
        chk("i_data_out", i_data_out, (m_owner == 1) ? mem_data_out : 16'h0);
        chk("d_data_out", d_data_out, (m_owner == 2) ? mem_data_out : 16'h0);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_data_in", mem_data_in, e_wdata);
        chk("mem_wr", 16'(mem_wr), 16'(e_wr));
        chk("mem_rd", 16'(mem_rd), 16'(e_rd));
        chk("err", 16'(err), 16'(m_owner != 0 && m_held == int'(MAX_HOLD)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int err_cnt;
        int err_at;
        rst = 1'b1;
        i_req = 0; i_wr = 0; i_rd = 0; i_addr = 0; i_data_in = 0;
        d_req = 0; d_wr = 0; d_rd = 0; d_addr = 0; d_data_in = 0;
        mem_stall = 0; mem_data_out = 0;

        // Reset state with reqs low, then with reqs high during reset.
        do_reset();
        chk("rst_i_gnt", 16'(i_gnt), 16'h0);
        chk("rst_mem_rd", 16'(mem_rd), 16'h0);
        rst = 1'b1; i_req = 1; d_req = 1;
        tick();
        chk("rst_i_stall", 16'(i_stall), 16'h1);
        chk("rst_d_gnt", 16'(d_gnt), 16'h0);
        i_req = 0; d_req = 0;
        do_reset();

        // D alone: grant on next edge, its address reaches memory, idle I not stalled.
        d_req = 1; d_addr = 16'h1238; d_rd = 1;
        tick();
        chk("d_alone_gnt", 16'(d_gnt), 16'h1);
        chk("d_alone_addr", mem_addr, 16'h1238);
        chk("d_alone_rd", 16'(mem_rd), 16'h1);
        chk("d_alone_istall", 16'(i_stall), 16'h0);
        d_req = 0; d_rd = 0;
        tick();

        // Tie after reset goes to D; D release hands straight to I.
        do_reset();
        i_req = 1; d_req = 1;
        tick();
        chk("tie1_d_gnt", 16'(d_gnt), 16'h1);
        repeat (5) tick();
        d_req = 0;
        tick();
        chk("handoff_i_gnt", 16'(i_gnt), 16'h1);
        chk("handoff_d_gnt", 16'(d_gnt), 16'h0);

        // I owns; D write attempt must not reach memory.
        i_addr = 16'h0444; i_wr = 0; i_rd = 1;
        d_req = 1; d_wr = 1; d_addr = 16'hBEEF; d_data_in = 16'h5555;
        repeat (3) begin
            tick();
            chk("nonown_wr", 16'(mem_wr), 16'h0);
            chk("nonown_addr", mem_addr, 16'h0444);
            chk("nonown_dstall", 16'(d_stall), 16'h1);
        end
        i_req = 0; i_rd = 0; d_req = 0; d_wr = 0;
        tick();
        tick();

        // last_served = I now; tie goes to D.
        i_req = 1; d_req = 1;
        tick();
        chk("tie2_d_gnt", 16'(d_gnt), 16'h1);
        // D releases while I idle -> last_served = D, next tie to I.
        i_req = 0; d_req = 0;
        tick();
        i_req = 1; d_req = 1;
        tick();
        chk("tie3_i_gnt", 16'(i_gnt), 16'h1);
        i_req = 0; d_req = 0;
        tick();

        // Watchdog: 40 granted cycles give exactly one err, on the 32nd.
        err_cnt = 0; err_at = 0;
        i_req = 1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (err === 1'b1) begin
                err_cnt++;
                err_at = k;
            end
        end
        chk("wd_err_count", 16'(err_cnt), 16'd1);
        chk("wd_err_cycle", 16'(err_at), 16'(MAX_HOLD));
        chk("wd_gnt_kept", 16'(i_gnt), 16'h1);
        i_req = 0;
        tick();

        // mem_stall and read data during D ownership.
        d_req = 1; d_rd = 1;
        tick();
        i_req = 1; mem_stall = 1; mem_data_out = 16'hA5A5;
        tick();
        chk("ms_d_stall", 16'(d_stall), 16'h1);
        chk("ms_i_stall", 16'(i_stall), 16'h1);
        chk("ms_d_data", d_data_out, 16'hA5A5);
        chk("ms_i_data", i_data_out, 16'h0);
        i_req = 0; mem_stall = 0;

        // Reset mid-burst abandons D, which is regranted after rst falls.
        rst = 1;
        tick();
        chk("mid_rst_dgnt", 16'(d_gnt), 16'h0);
        chk("mid_rst_rd", 16'(mem_rd), 16'h0);
        rst = 0;
        tick();
        chk("regrant_dgnt", 16'(d_gnt), 16'h1);
        d_req = 0; d_rd = 0;
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) i_req = ~i_req;
            if ($urandom_range(0, 7) == 0) d_req = ~d_req;
            rst          = ($urandom_range(0, 99) == 0);
            i_wr         = 1'($urandom);
            i_rd         = 1'($urandom);
            d_wr         = 1'($urandom);
            d_rd         = 1'($urandom);
            i_addr       = 16'($urandom);
            d_addr       = 16'($urandom);
            i_data_in    = 16'($urandom);
            d_data_in    = 16'($urandom);
            mem_data_out = 16'($urandom);
            mem_stall    = 1'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
